data_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single data `memory` instance between the `riscv_core` data port (port 0) and a second master (port 1: program/data loader, debug or DMA). It multiplexes requests onto the memory's `rd_addr`/`wr`/`wr_addr`/`wr_data` pins and routes `rd_data` back to the requester that issued the read. Grants are round-robin, with an optional bounded bus lock for atomic read-modify-write sequences.

---
 rtl/data_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of the single-ported data memory: round-robin grants,
// a bounded bus lock for read-modify-write, and one-cycle read-data routing back to the requester.
module data_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [1:0]        m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [1:0]        m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [1:0]        mem_wr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e       lock_state_q, lock_state_d;
    logic              lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]  lock_cnt_q,   lock_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              rd_pend_q,    rd_pend_d;
    logic              rd_tag_q,     rd_tag_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;

    logic              gnt0_s;
    logic              gnt1_s;
    logic              any_gnt_s;
    logic [1:0]        sel_wr_s;
    logic              sel_lock_s;
    logic              rd_xfer_s;

    // Grant selection: reset blocks everything, a lock owner excludes the other port,
    // otherwise the port that did not win last time takes a tie.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (lock_state_q == LK_LOCKED) begin
            gnt0_s = m0_valid && !lock_owner_q;
            gnt1_s = m1_valid &&  lock_owner_q;
        end else if (m0_valid && m1_valid) begin
            gnt0_s =  last_grant_q;
            gnt1_s = !last_grant_q;
        end else begin
            gnt0_s = m0_valid;
            gnt1_s = m1_valid;
        end
    end

    assign m0_ready  = gnt0_s;
    assign m1_ready  = gnt1_s;
    assign any_gnt_s = gnt0_s || gnt1_s;

    // Payload mux onto the memory pins; with no grant port 0's address idles on rd_addr.
    always_comb begin
        sel_wr_s    = 2'b00;
        sel_lock_s  = 1'b0;
        mem_rd_addr = m0_addr;
        mem_wr_addr = m0_addr;
        mem_wr_data = m0_wdata;
        if (gnt1_s) begin
            sel_wr_s    = m1_wr;
            sel_lock_s  = m1_lock;
            mem_rd_addr = m1_addr;
            mem_wr_addr = m1_addr;
            mem_wr_data = m1_wdata;
        end else begin
            sel_wr_s    = m0_wr;
            sel_lock_s  = m0_lock;
            mem_rd_addr = m0_addr;
            mem_wr_addr = m0_addr;
            mem_wr_data = m0_wdata;
        end
    end

    assign mem_wr    = any_gnt_s ? sel_wr_s : 2'b00;
    assign rd_xfer_s = any_gnt_s && (sel_wr_s == 2'b00);

    // Lock FSM: the count tracks cycles spent locked; reaching LOCK_MAX forces release
    // at the end of that cycle even if the owner keeps asking for the lock.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        case (lock_state_q)
            LK_UNLOCKED: begin
                if (any_gnt_s && sel_lock_s) begin
                    lock_state_d = LK_LOCKED;
                    lock_owner_d = gnt1_s;
                    lock_cnt_d   = CNT_ONE;
                end else begin
                    lock_cnt_d   = CNT_ZERO;
                end
            end
            LK_LOCKED: begin
                if (lock_cnt_q == CNT_MAX) begin
                    lock_state_d = LK_UNLOCKED;
                    lock_cnt_d   = CNT_ZERO;
                end else if (any_gnt_s && !sel_lock_s) begin
                    lock_state_d = LK_UNLOCKED;
                    lock_cnt_d   = CNT_ZERO;
                end else begin
                    lock_cnt_d   = lock_cnt_q + CNT_ONE;
                end
            end
            default: begin
                lock_state_d = LK_UNLOCKED;
                lock_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Round-robin pointer and read-return bookkeeping.
    always_comb begin
        last_grant_d = last_grant_q;
        rd_tag_d     = rd_tag_q;
        rd_pend_d    = rd_xfer_s;
        if (any_gnt_s) begin
            last_grant_d = gnt1_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (rd_xfer_s) begin
            rd_tag_d = gnt1_s;
        end else begin
            rd_tag_d = rd_tag_q;
        end
    end

    // A read accepted just before reset must not surface, so rvalid is masked by rst.
    assign m0_rvalid = !rst && rd_pend_q && !rd_tag_q;
    assign m1_rvalid = !rst && rd_pend_q &&  rd_tag_q;

    // Read data passes straight through while valid and is held afterwards.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        m0_rdata = rdata0_q;
        m1_rdata = rdata1_q;
        if (m0_rvalid) begin
            rdata0_d = mem_rd_data;
            m0_rdata = mem_rd_data;
        end else begin
            rdata0_d = rdata0_q;
            m0_rdata = rst ? {DATA_W{1'b0}} : rdata0_q;
        end
        if (m1_rvalid) begin
            rdata1_d = mem_rd_data;
            m1_rdata = mem_rd_data;
        end else begin
            rdata1_d = rdata1_q;
            m1_rdata = rst ? {DATA_W{1'b0}} : rdata1_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_q <= LK_UNLOCKED;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= CNT_ZERO;
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_tag_q     <= 1'b0;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
        end else begin
            lock_state_q <= lock_state_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_tag_q     <= rd_tag_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios then random traffic, with a byte-level
// memory model, a transaction-level arbitration model and a read-data scoreboard.
module tb_data_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_valid = 1'b0, m1_valid = 1'b0;
    logic          m0_ready, m1_ready;
    logic [1:0]    m0_wr = 2'b00, m1_wr = 2'b00;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_lock = 1'b0, m1_lock = 1'b0;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [1:0]    mem_wr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    // Memory the DUT drives (environment) and the bench's own reference copy.
    logic [7:0] env_mem [0:255];
    logic [7:0] ref_mem [0:255];

    always @(posedge clk) begin
        case (mem_wr)
            2'b01: env_mem[mem_wr_addr[7:0]] <= mem_wr_data[7:0];
            2'b10: begin
                env_mem[mem_wr_addr[7:0]]         <= mem_wr_data[7:0];
                env_mem[mem_wr_addr[7:0] + 8'd1]  <= mem_wr_data[15:8];
            end
            2'b11: begin
                env_mem[mem_wr_addr[7:0]]         <= mem_wr_data[7:0];
                env_mem[mem_wr_addr[7:0] + 8'd1]  <= mem_wr_data[15:8];
                env_mem[mem_wr_addr[7:0] + 8'd2]  <= mem_wr_data[23:16];
                env_mem[mem_wr_addr[7:0] + 8'd3]  <= mem_wr_data[31:24];
            end
            default: ;
        endcase
        mem_rd_data <= {env_mem[{mem_rd_addr[7:2], 2'b11}], env_mem[{mem_rd_addr[7:2], 2'b10}],
                        env_mem[{mem_rd_addr[7:2], 2'b01}], env_mem[{mem_rd_addr[7:2], 2'b00}]};
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
        int nbytes;
        nbytes = (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
        for (int k = 0; k < nbytes; k++) ref_mem[a[7:0] + 8'(k)] = d[8*k +: 8];
    endtask

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pending requests per port, and the arbitration model state.
    logic        rq_valid [2];
    logic [1:0]  rq_wr    [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic        rq_lock  [2];
    logic        tb_rst = 1'b1;
    int          lk_owner = -1;
    int          lk_start = 0;
    int          last_g   = 1;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    task automatic set_req(input int p, input logic [1:0] wr, input logic [31:0] a,
                           input logic [31:0] d, input logic lk);
        rq_valid[p] = 1'b1;
        rq_wr[p]    = wr;
        rq_addr[p]  = a;
        rq_wdata[p] = d;
        rq_lock[p]  = lk;
    endtask

    task automatic idle_all();
        rq_valid[0] = 1'b0;
        rq_valid[1] = 1'b0;
    endtask

    // One clock cycle: drive pending requests, predict the grant, check it, advance the model.
    task automatic step();
        int g;
        logic [1:0] ewr;
        @(negedge clk);
        cyc++;
        rst      = tb_rst;
        m0_valid = rq_valid[0]; m0_wr = rq_wr[0]; m0_addr = rq_addr[0];
        m0_wdata = rq_wdata[0]; m0_lock = rq_lock[0];
        m1_valid = rq_valid[1]; m1_wr = rq_wr[1]; m1_addr = rq_addr[1];
        m1_wdata = rq_wdata[1]; m1_lock = rq_lock[1];
        if (tb_rst) sb_q.delete();
        #1;
        if (tb_rst)                       g = -1;
        else if (lk_owner >= 0)           g = rq_valid[lk_owner] ? lk_owner : -1;
        else if (rq_valid[0] && rq_valid[1]) g = 1 - last_g;
        else if (rq_valid[0])             g = 0;
        else if (rq_valid[1])             g = 1;
        else                              g = -1;
        chk("m0_ready", 32'(m0_ready), 32'(g == 0));
        chk("m1_ready", 32'(m1_ready), 32'(g == 1));
        ewr = (g >= 0) ? rq_wr[g] : 2'b00;
        chk("mem_wr", 32'(mem_wr), 32'(ewr));
        if (g >= 0) begin
            if (rq_wr[g] == 2'b00) sb_q.push_back('{g, ref_word(rq_addr[g]), cyc + 1});
            else ref_write(rq_wr[g], rq_addr[g], rq_wdata[g]);
        end
        if (tb_rst) begin
            lk_owner = -1;
            last_g   = 1;
        end else begin
            if (lk_owner >= 0) begin
                // Locked cycles are lk_start+1 .. lk_start+LMAX.
                if (cyc == lk_start + LMAX || (g == lk_owner && !rq_lock[g])) lk_owner = -1;
            end else if (g >= 0 && rq_lock[g]) begin
                lk_owner = g;
                lk_start = cyc;
            end
            if (g >= 0) last_g = g;
        end
        if (g >= 0) rq_valid[g] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        idle_all();
        tb_rst = 1'b1;
        repeat (n) step();
        tb_rst = 1'b0;
    endtask

    // Monitor: each cycle either the scoreboard head is due and must appear, or no rvalid.
    logic [31:0] hold [2];
    initial begin
        exp_t e;
        hold[0] = '0;
        hold[1] = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold[0] = '0;
                hold[1] = '0;
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                chk("rvalid_tag", 32'({m1_rvalid, m0_rvalid}), (e.port == 0) ? 32'd1 : 32'd2);
                chk("rdata", (e.port == 0) ? m0_rdata : m1_rdata, e.data);
                hold[e.port] = e.data;
            end else begin
                chk("rvalid_idle", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            end
            if (!m0_rvalid) chk("m0_rdata_hold", m0_rdata, hold[0]);
            if (!m1_rvalid) chk("m1_rdata_hold", m1_rdata, hold[1]);
        end
    end

    initial begin
        int          kind;
        logic [1:0]  w;
        logic [31:0] a;
        rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq_wr[p] = 2'b00; rq_addr[p] = '0; rq_wdata[p] = '0; rq_lock[p] = 1'b0;
        end
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        env_mem[16] = 8'h11; env_mem[17] = 8'h22; env_mem[18] = 8'h33; env_mem[19] = 8'h44;
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;

        do_reset(2);

        // Contention: both continuously valid, grants alternate starting with port 0.
        for (int i = 0; i < 6; i++) begin
            if (!rq_valid[0]) set_req(0, 2'b00, 32'(4 * i), '0, 1'b0);
            if (!rq_valid[1]) set_req(1, 2'b00, 32'(32 + 4 * i), '0, 1'b0);
            step();
            chk("contention_m0_ready", 32'(m0_ready), 32'(i % 2 == 0));
        end
        idle_all(); step(); step();

        // Single read of the initialised word.
        set_req(0, 2'b00, 32'h10, '0, 1'b0);
        step();
        idle_all();
        step();
        chk("single_rvalid", 32'(m0_rvalid), 32'd1);
        chk("single_rdata", m0_rdata, 32'h44332211);
        chk("single_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // Byte write on port 1 then word read on port 0.
        set_req(1, 2'b01, 32'h21, 32'h000000AB, 1'b0);
        step();
        idle_all();
        set_req(0, 2'b00, 32'h20, '0, 1'b0);
        step();
        idle_all();
        step();
        chk("wr_rd_byte1", 32'(m0_rdata[15:8]), 32'h000000AB);

        // Lock: m1 waits through m0's locked read and unlocking write.
        do_reset(1);
        set_req(0, 2'b00, 32'h10, '0, 1'b1);
        set_req(1, 2'b00, 32'h14, '0, 1'b0);
        step();
        set_req(0, 2'b11, 32'h08, $urandom, 1'b0);
        step();
        chk("lock_m1_stalled", 32'(m1_ready), 32'd0);
        step();
        chk("lock_m1_after", 32'(m1_ready), 32'd1);
        idle_all(); step();

        // Forced release after LMAX locked cycles with an idle owner.
        do_reset(1);
        set_req(0, 2'b00, 32'h18, '0, 1'b1);
        step();
        set_req(1, 2'b00, 32'h1C, '0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("forced_m1_ready", 32'(m1_ready), 32'(k == 5));
        end
        idle_all(); step();

        // Reset right after a read is accepted.
        do_reset(1);
        set_req(0, 2'b00, 32'h10, '0, 1'b0);
        step();
        idle_all();
        tb_rst = 1'b1;
        step();
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        tb_rst = 1'b0;
        set_req(0, 2'b00, 32'h04, '0, 1'b0);
        set_req(1, 2'b00, 32'h08, '0, 1'b0);
        step();
        chk("post_rst_tie_m0", 32'(m0_ready), 32'd1);
        idle_all(); step(); step();

        // Random traffic with occasional locks and resets.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq_valid[p] && $urandom_range(0, 99) < 55) begin
                    kind = $urandom_range(0, 5);
                    w    = (kind < 3) ? 2'b00 : 2'(kind - 2);
                    a    = 32'($urandom_range(0, 63));
                    if (w == 2'b11) a = a & 32'hFFFF_FFFC;
                    if (w == 2'b10) a = a & 32'hFFFF_FFFE;
                    set_req(p, w, a, $urandom, ($urandom_range(0, 3) == 0));
                end
            end
            tb_rst = ($urandom_range(0, 399) == 0);
            step();
            tb_rst = 1'b0;
        end
        idle_all();
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
